// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start 0, 8 data bits LSB first, parity, stop 1.
// Emits one-cycle done/parity_err/frame_err strobes and a saturating bad-frame count.
module serial_frame_rx #(
  parameter bit PARITY_ODD = 1'b1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in,
  output logic [7:0]           out_byte,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_PERR,
    S_FERR,
    S_WAIT
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic [7:0]           out_byte_q, out_byte_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      acc_q      <= 1'b0;
      out_byte_q <= 8'h00;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      out_byte_q <= out_byte_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    out_byte_d = out_byte_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!in) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
          acc_d   = 1'b0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = in;
        acc_d          = acc_q ^ in;
        if (cnt_q == 3'd7) state_d = S_PARITY;
        else               cnt_d   = cnt_q + 3'd1;
      end
      S_PARITY: begin
        acc_d   = acc_q ^ in;
        state_d = S_STOP;
      end
      S_STOP: begin
        // out_byte loads on the edge into DONE so it is valid while done=1
        if (in && (acc_q == PARITY_ODD)) begin
          state_d    = S_DONE;
          out_byte_d = shift_q;
        end else begin
          state_d = in ? S_PERR : S_FERR;
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
        end
      end
      S_DONE, S_PERR: begin
        // a 0 here is the start bit of a back-to-back frame
        if (!in) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
          acc_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FERR: state_d = in ? S_IDLE : S_WAIT;
      S_WAIT: if (in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign out_byte   = out_byte_q;
  assign done       = (state_q == S_DONE);
  assign parity_err = (state_q == S_PERR);
  assign frame_err  = (state_q == S_FERR);
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: three instances (odd/8, odd/2, even/8) on one shared line,
// checked against a frame-scanning reference model plus a constant vector table.
module tb_serial_frame_rx;

  localparam int MAXN = 600;

  logic clk = 1'b0;
  logic areset;
  logic in;
  always #5 clk = ~clk;

  logic [7:0] ob_a, ob_b, ob_c;
  logic       done_a, done_b, done_c;
  logic       pe_a, pe_b, pe_c;
  logic       fe_a, fe_b, fe_c;
  logic [7:0] ec_a, ec_c;
  logic [1:0] ec_b;

  serial_frame_rx #(.PARITY_ODD(1'b1), .ERR_CNT_W(8)) u_a (
    .clk(clk), .areset(areset), .in(in), .out_byte(ob_a), .done(done_a),
    .parity_err(pe_a), .frame_err(fe_a), .err_count(ec_a));
  serial_frame_rx #(.PARITY_ODD(1'b1), .ERR_CNT_W(2)) u_b (
    .clk(clk), .areset(areset), .in(in), .out_byte(ob_b), .done(done_b),
    .parity_err(pe_b), .frame_err(fe_b), .err_count(ec_b));
  serial_frame_rx #(.PARITY_ODD(1'b0), .ERR_CNT_W(8)) u_c (
    .clk(clk), .areset(areset), .in(in), .out_byte(ob_c), .done(done_c),
    .parity_err(pe_c), .frame_err(fe_c), .err_count(ec_c));

  typedef struct {
    bit         in;
    bit         done;
    bit         perr;
    bit         ferr;
    logic [7:0] ob;
    int         ec;
  } vec_t;

  int checks = 0;
  int failures = 0;

  bit         stim[$];
  bit         e_done [3][MAXN];
  bit         e_perr [3][MAXN];
  bit         e_ferr [3][MAXN];
  logic [7:0] e_byte [3][MAXN];
  logic [7:0] e_ob   [3][MAXN];
  int         e_ec   [3][MAXN];
  logic [7:0] m_ob [3];
  int         m_ec [3];
  int         done_t[$];
  int         b_ec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get(input int d, output logic dn, output logic pe, output logic fe,
                     output logic [7:0] o, output logic [31:0] e);
    case (d)
      0: begin dn = done_a; pe = pe_a; fe = fe_a; o = ob_a; e = {24'd0, ec_a}; end
      1: begin dn = done_b; pe = pe_b; fe = fe_b; o = ob_b; e = {30'd0, ec_b}; end
      default: begin dn = done_c; pe = pe_c; fe = fe_c; o = ob_c; e = {24'd0, ec_c}; end
    endcase
  endtask

  // Reference: scan the bit stream for frames; status shows after the stop-bit edge.
  task automatic model(input int d);
    int         n;
    int         i;
    int         j;
    bit         odd;
    int         sat;
    logic [7:0] b;
    logic [7:0] ob;
    int         ec;
    n   = stim.size();
    i   = 0;
    odd = (d != 2);
    sat = (d == 1) ? 3 : 255;
    ob  = m_ob[d];
    ec  = m_ec[d];
    for (int k = 0; k < n; k++) begin
      e_done[d][k] = 1'b0; e_perr[d][k] = 1'b0; e_ferr[d][k] = 1'b0; e_byte[d][k] = 8'h00;
    end
    while (i < n) begin
      if (stim[i]) i++;
      else if (i + 10 >= n) i = n;
      else begin
        for (int m = 0; m < 8; m++) b[m] = stim[i + 1 + m];
        if (!stim[i + 10]) begin
          e_ferr[d][i + 10] = 1'b1;
          j = i + 11;
          while (j < n && !stim[j]) j++;
          i = j + 1;
        end else if (((^b) ^ stim[i + 9]) == odd) begin
          e_done[d][i + 10] = 1'b1;
          e_byte[d][i + 10] = b;
          i = i + 11;
        end else begin
          e_perr[d][i + 10] = 1'b1;
          i = i + 11;
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      if (e_done[d][k]) ob = e_byte[d][k];
      if ((e_perr[d][k] || e_ferr[d][k]) && ec < sat) ec++;
      e_ob[d][k] = ob;
      e_ec[d][k] = ec;
    end
  endtask

  task automatic check_model(input string tag, input int k);
    logic dn, pe, fe;
    logic [7:0] o;
    logic [31:0] e;
    for (int d = 0; d < 3; d++) begin
      get(d, dn, pe, fe, o, e);
      chk($sformatf("%s u%0d c%0d done", tag, d, k), dn, e_done[d][k]);
      chk($sformatf("%s u%0d c%0d parity_err", tag, d, k), pe, e_perr[d][k]);
      chk($sformatf("%s u%0d c%0d frame_err", tag, d, k), fe, e_ferr[d][k]);
      chk($sformatf("%s u%0d c%0d out_byte", tag, d, k), o, e_ob[d][k]);
      chk($sformatf("%s u%0d c%0d err_count", tag, d, k), e, e_ec[d][k]);
    end
    if (done_a) done_t.push_back(k);
    if (pe_b) b_ec.push_back({30'd0, ec_b});
  endtask

  task automatic prep();
    if (stim.size() > MAXN) begin
      $display("FAIL stream_length: got %0d expected <= %0d", stim.size(), MAXN);
      $fatal(1, "stream too long");
    end
    for (int d = 0; d < 3; d++) model(d);
    done_t.delete();
    b_ec.delete();
  endtask

  task automatic finish_stream();
    int n;
    n = stim.size();
    for (int d = 0; d < 3; d++) begin
      m_ob[d] = e_ob[d][n - 1];
      m_ec[d] = e_ec[d][n - 1];
    end
  endtask

  task automatic run_stream(input string tag);
    prep();
    for (int k = 0; k < stim.size(); k++) begin
      in = stim[k];
      @(posedge clk); #1;
      check_model(tag, k);
    end
    finish_stream();
  endtask

  task automatic step(input bit b);
    in = b;
    @(posedge clk); #1;
  endtask

  task automatic push_ones(input int n);
    for (int k = 0; k < n; k++) stim.push_back(1'b1);
  endtask

  // Parity bit chosen for odd parity; par_good=0 inverts it.
  task automatic push_frame(input logic [7:0] b, input bit par_good, input bit stop);
    stim.push_back(1'b0);
    for (int k = 0; k < 8; k++) stim.push_back(b[k]);
    stim.push_back(par_good ? ~(^b) : (^b));
    stim.push_back(stop);
  endtask

  task automatic chk_zero(input string tag);
    logic dn, pe, fe;
    logic [7:0] o;
    logic [31:0] e;
    for (int d = 0; d < 3; d++) begin
      get(d, dn, pe, fe, o, e);
      chk($sformatf("%s u%0d outputs", tag, d), {dn, pe, fe, o, e[7:0]}, 19'd0);
    end
  endtask

  function automatic vec_t mk(bit i, bit d, logic [7:0] o);
    vec_t v;
    v.in = i; v.done = d; v.perr = 1'b0; v.ferr = 1'b0; v.ob = o; v.ec = 0;
    return v;
  endfunction

  vec_t tbl[14];
  int   sat_exp[5];

  initial begin
    // idle, start, 0x4B LSB first, odd parity 1, stop 1, idle
    tbl[0]  = mk(1'b1, 1'b0, 8'h00);
    tbl[1]  = mk(1'b1, 1'b0, 8'h00);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00);
    tbl[3]  = mk(1'b1, 1'b0, 8'h00);
    tbl[4]  = mk(1'b1, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 8'h00);
    tbl[6]  = mk(1'b1, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00);
    tbl[9]  = mk(1'b1, 1'b0, 8'h00);
    tbl[10] = mk(1'b0, 1'b0, 8'h00);
    tbl[11] = mk(1'b1, 1'b0, 8'h00);
    tbl[12] = mk(1'b1, 1'b1, 8'h4B);
    tbl[13] = mk(1'b1, 1'b0, 8'h4B);
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    for (int d = 0; d < 3; d++) begin m_ob[d] = 8'h00; m_ec[d] = 0; end

    areset = 1'b1;
    in     = 1'b1;
    #12;
    chk_zero("reset");
    #5;
    areset = 1'b0;

    // vector table
    stim.delete();
    for (int k = 0; k < 14; k++) stim.push_back(tbl[k].in);
    prep();
    for (int k = 0; k < 14; k++) begin
      in = tbl[k].in;
      @(posedge clk); #1;
      chk($sformatf("tbl c%0d done", k), done_a, tbl[k].done);
      chk($sformatf("tbl c%0d errs", k), {pe_a, fe_a}, {tbl[k].perr, tbl[k].ferr});
      chk($sformatf("tbl c%0d out_byte", k), ob_a, tbl[k].ob);
      chk($sformatf("tbl c%0d err_count", k), ec_a, tbl[k].ec);
      check_model("tbl", k);
    end
    finish_stream();

    // parity error keeps previous byte
    stim.delete();
    push_ones(2); push_frame(8'h4B, 1'b0, 1'b1); push_ones(13);
    run_stream("perr");
    chk("perr out_byte held", ob_a, 8'h4B);
    chk("perr err_count", ec_a, 8'd1);

    // framing error, zeros in WAIT ignored, then a good frame
    stim.delete();
    push_frame(8'hA5, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) stim.push_back(1'b0);
    push_ones(1); push_frame(8'h3C, 1'b1, 1'b1); push_ones(13);
    run_stream("ferr");
    chk("ferr out_byte", ob_a, 8'h3C);
    chk("ferr err_count", ec_a, 8'd2);
    chk("ferr done count", done_t.size(), 1);

    // back-to-back: second start bit lands in the DONE cycle
    stim.delete();
    push_ones(2); push_frame(8'h55, 1'b1, 1'b1); push_frame(8'hFF, 1'b1, 1'b1); push_ones(13);
    run_stream("b2b");
    chk("b2b done count", done_t.size(), 2);
    if (done_t.size() == 2) chk("b2b done spacing", done_t[1] - done_t[0], 11);
    chk("b2b out_byte", ob_a, 8'hFF);

    // async reset between edges during data bit 4 of 0xC3
    step(1'b1); step(1'b1); step(1'b0);
    for (int k = 0; k < 4; k++) begin
      step((k < 2) ? 1'b1 : 1'b0);
      chk($sformatf("partial bit%0d done", k), {done_a, done_b, done_c}, 3'b000);
    end
    in = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    chk_zero("async reset");
    @(posedge clk); #1;
    chk_zero("reset held");
    areset = 1'b0;
    for (int d = 0; d < 3; d++) begin m_ob[d] = 8'h00; m_ec[d] = 0; end
    stim.delete();
    push_ones(2); push_frame(8'h96, 1'b1, 1'b1); push_ones(13);
    run_stream("post_reset");
    chk("post_reset out_byte", ob_a, 8'h96);
    chk("post_reset done count", done_t.size(), 1);

    // saturation on the 2-bit counter
    stim.delete();
    push_ones(2);
    for (int k = 0; k < 5; k++) begin
      push_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
      push_ones(2);
    end
    push_ones(13);
    run_stream("sat");
    chk("sat pulse count", b_ec.size(), 5);
    for (int k = 0; k < 5 && k < b_ec.size(); k++)
      chk($sformatf("sat step%0d err_count", k), b_ec[k], sat_exp[k]);

    // randomized streams
    for (int r = 0; r < 4; r++) begin
      stim.delete();
      while (stim.size() < 300) begin
        case ($urandom_range(0, 4))
          0: push_ones($urandom_range(1, 4));
          1: push_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
          2: push_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
          3: push_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b0);
          default: begin
            int len;
            len = $urandom_range(1, 15);
            for (int k = 0; k < len; k++) stim.push_back($urandom_range(0, 1) == 1);
          end
        endcase
      end
      push_ones(13);
      run_stream($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
